md_alu: RTL and testbench

MD_ALU -- requirements
Module: md_alu

---
 rtl/md_alu_pkg.sv | 32 +++
 rtl/md_alu_iter.sv | 101 ++++++++++
 rtl/md_alu.sv | 163 ++++++++++++++++
 tb/tb_md_alu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_alu_pkg.sv
// md_alu_pkg: shared types for the md_alu multiply/divide ALU.
//   alu_op_e    - ALUControl operation codes
//   alu_state_e - sequencing FSM states
//   iter_cnt_width() - width of the iterative datapath step counter
package md_alu_pkg;

    typedef enum logic [3:0] {
        OpAnd   = 4'b0000,
        OpOr    = 4'b0001,
        OpAdd   = 4'b0010,
        OpXor   = 4'b0011,
        OpSltu  = 4'b0101,
        OpSub   = 4'b0110,
        OpSlt   = 4'b0111,
        OpMultu = 4'b1000,
        OpDivu  = 4'b1001,
        OpNor   = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } alu_state_e;

    // One extra bit so the counter can hold the value WIDTH itself.
    function automatic int unsigned iter_cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/md_alu_iter.sv
// md_alu_iter: iterative unsigned multiply (shift-add) / restoring divide datapath.
// One bit per step; the caller runs exactly WIDTH steps after a start.
//   clk, rst_n     - clock, async active-low reset
//   start_i        - load operands and clear the step counter
//   div_i          - with start_i: 1 = divide, 0 = multiply
//   step_i         - advance one bit this cycle
//   a_i, b_i       - multiplicand/multiplier or dividend/divisor
//   last_o         - the current step is the final one
//   hi_nxt_o       - high half / remainder after the current step
//   lo_nxt_o       - low half / quotient after the current step
module md_alu_iter
    import md_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_nxt_o,
    output logic [WIDTH-1:0] lo_nxt_o
);

    localparam int unsigned CntW = iter_cnt_width(WIDTH);

    // acc: product high half / partial remainder
    // sh:  multiplier shifting out, product low half / dividend shifting out, quotient in
    // opnd: multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_cand;
    logic [WIDTH-1:0] div_diff;
    logic             div_fit;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] sh_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
        div_cand = {acc_q, sh_q[WIDTH-1]};
        div_fit  = div_cand >= {1'b0, opnd_q};
        // Only used when div_fit, so the result always fits in WIDTH bits.
        div_diff = div_cand[WIDTH-1:0] - opnd_q;

        if (div_q) begin
            acc_step = div_fit ? div_diff : div_cand[WIDTH-1:0];
            sh_step  = {sh_q[WIDTH-2:0], div_fit};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            sh_step  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        acc_d  = acc_q;
        sh_d   = sh_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            acc_d  = '0;
            sh_d   = div_i ? a_i : b_i;
            opnd_d = div_i ? b_i : a_i;
            div_d  = div_i;
            cnt_d  = '0;
        end else if (step_i && (cnt_q != CntW'(WIDTH))) begin
            acc_d = acc_step;
            sh_d  = sh_step;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sh_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last_o   = (cnt_q == CntW'(WIDTH - 1));
    assign hi_nxt_o = acc_step;
    assign lo_nxt_o = sh_step;

endmodule

// File: rtl/md_alu.sv
// md_alu: MIPS-style ALU with single-cycle logic/arith ops and iterative MULTU/DIVU.
// One operation outstanding at a time; valid/ready handshakes on both sides.
//   clk, rst_n          - clock, async active-low reset
//   srcA, srcB          - operands (captured on acceptance)
//   ALUControl          - operation code
//   in_valid, in_ready  - request handshake (ready only when idle)
//   out_valid, out_ready- result handshake (result held until consumed)
//   ALUResult, Zero     - registered result and its zero flag
//   Hi, Lo              - architectural HI/LO, written by MULTU/DIVU only
//   DivZero             - last completed DIVU had a zero divisor
module md_alu
    import md_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       ALUControl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             divzero_q, divzero_d;
    // Divisor-was-zero flag, held until the DIVU completes.
    logic             divz_pend_q, divz_pend_d;

    alu_op_e          alu_op;
    logic [WIDTH-1:0] simple_res;

    logic             iter_start;
    logic             iter_div;
    logic             iter_step;
    logic             iter_last;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    md_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (iter_start),
        .div_i    (iter_div),
        .step_i   (iter_step),
        .a_i      (srcA),
        .b_i      (srcB),
        .last_o   (iter_last),
        .hi_nxt_o (iter_hi),
        .lo_nxt_o (iter_lo)
    );

    // Single-cycle operations, evaluated on the live operands at acceptance.
    always_comb begin
        alu_op = alu_op_e'(ALUControl);
        case (alu_op)
            OpAnd:   simple_res = srcA & srcB;
            OpOr:    simple_res = srcA | srcB;
            OpAdd:   simple_res = srcA + srcB;
            OpXor:   simple_res = srcA ^ srcB;
            OpSub:   simple_res = srcA - srcB;
            OpSlt:   simple_res = WIDTH'($signed(srcA) < $signed(srcB));
            OpSltu:  simple_res = WIDTH'(srcA < srcB);
            OpNor:   simple_res = ~(srcA | srcB);
            default: simple_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        divzero_d   = divzero_q;
        divz_pend_d = divz_pend_q;
        iter_start  = 1'b0;
        iter_div    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (alu_op == OpMultu) begin
                        iter_start = 1'b1;
                        state_d    = StMul;
                    end else if (alu_op == OpDivu) begin
                        iter_start  = 1'b1;
                        iter_div    = 1'b1;
                        divz_pend_d = (srcB == '0);
                        state_d     = StDiv;
                    end else begin
                        result_d = simple_res;
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                // Commit on the final step so the op spends exactly WIDTH cycles here.
                if (iter_last) begin
                    hi_d     = iter_hi;
                    lo_d     = iter_lo;
                    result_d = iter_lo;
                    state_d  = StDone;
                end
            end
            StDiv: begin
                if (iter_last) begin
                    hi_d      = iter_hi;
                    lo_d      = iter_lo;
                    result_d  = iter_lo;
                    divzero_d = divz_pend_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign iter_step = (state_q == StMul) || (state_q == StDiv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            divzero_q   <= 1'b0;
            divz_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            divzero_q   <= divzero_d;
            divz_pend_q <= divz_pend_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign ALUResult = result_q;
    assign Zero      = (result_q == '0);
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign DivZero   = divzero_q;

endmodule

// File: tb/tb_md_alu.sv
module tb_md_alu;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  srcA, srcB;
    logic [3:0]    ALUControl;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  ALUResult, Hi, Lo;
    logic          Zero, DivZero;

    md_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .srcA       (srcA),
        .srcB       (srcB),
        .ALUControl (ALUControl),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Hi         (Hi),
        .Lo         (Lo),
        .DivZero    (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference architectural state
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic        m_dz = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res, hi, lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vtab[14];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic [31:0] hi,
                                input logic [31:0] lo, input logic dz, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi; v.lo = lo; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model straight from the opcode definitions.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output int lat);
        logic [63:0] p;
        lat = 1;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a + b;
            4'b0011: res = a ^ b;
            4'b0110: res = a - b;
            4'b0111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: res = (a < b) ? 32'd1 : 32'd0;
            4'b1100: res = ~(a | b);
            4'b1000: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                res = m_lo;
                lat = W + 1;
            end
            4'b1001: begin
                if (b == 32'h0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                    m_dz = 1'b1;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                    m_dz = 1'b0;
                end
                res = m_lo;
                lat = W + 1;
            end
            default: res = 32'h0;
        endcase
    endfunction

    // Issue one op and wait for out_valid; leaves the DUT holding its result.
    // Called #1 after a rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_ok);
        int g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("ready_timeout", {63'h0, in_ready}, 64'h1);
        srcA = a; srcB = b; ALUControl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operand changes after acceptance must not matter.
        srcA = $urandom; srcB = $urandom; ALUControl = 4'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [3:0] rops[12];

    initial begin
        int          lat;
        logic        busy_ok;
        logic [31:0] exp_res;
        int          exp_lat;
        logic [31:0] held;
        int          unstable;
        int          seen;

        rst_n = 1'b1; srcA = '0; srcB = '0; ALUControl = '0;
        in_valid = 1'b0; out_ready = 1'b0;

        vtab[0]  = mk(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 1);
        vtab[1]  = mk(4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 32'h0, 1'b0, 1);
        vtab[2]  = mk(4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 1);
        vtab[3]  = mk(4'b0110, 32'h5, 32'h7, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0, 1);
        vtab[4]  = mk(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 32'h1, 1'b0, 33);
        vtab[5]  = mk(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'hFFFF_FFFE, 32'h1,
                      1'b0, 1);
        vtab[6]  = mk(4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 1'b0, 33);
        vtab[7]  = mk(4'b1001, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 1'b1, 33);
        vtab[8]  = mk(4'b0001, 32'h1234_5678, 32'h0F0F_0000, 32'h1F3F_5678, 32'd9, 32'hFFFF_FFFF,
                      1'b1, 1);
        vtab[9]  = mk(4'b0011, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 32'd9, 32'hFFFF_FFFF,
                      1'b1, 1);
        vtab[10] = mk(4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 1'b1, 1);
        vtab[11] = mk(4'b0100, 32'h1, 32'h2, 32'h0, 32'd9, 32'hFFFF_FFFF, 1'b1, 1);
        vtab[12] = mk(4'b1000, 32'd3, 32'd5, 32'd15, 32'd0, 32'd15, 1'b1, 33);
        vtab[13] = mk(4'b1001, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5, 32'h1999_9999,
                      1'b0, 33);

        rops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111,
                 4'b0101, 4'b1100, 4'b1000, 4'b1001, 4'b0100, 4'b1111};

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_result", {32'h0, ALUResult}, 64'h0);
        check("rst_zero", {63'h0, Zero}, 64'h1);
        check("rst_hi", {32'h0, Hi}, 64'h0);
        check("rst_lo", {32'h0, Lo}, 64'h0);
        check("rst_divzero", {63'h0, DivZero}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            model(vtab[i].op, vtab[i].a, vtab[i].b, exp_res, exp_lat);
            issue(vtab[i].op, vtab[i].a, vtab[i].b, lat, busy_ok);
            check($sformatf("vec%0d_res", i), {32'h0, ALUResult}, {32'h0, vtab[i].res});
            check($sformatf("vec%0d_zero", i), {63'h0, Zero}, {63'h0, vtab[i].res == 32'h0});
            check($sformatf("vec%0d_hi", i), {32'h0, Hi}, {32'h0, vtab[i].hi});
            check($sformatf("vec%0d_lo", i), {32'h0, Lo}, {32'h0, vtab[i].lo});
            check($sformatf("vec%0d_dz", i), {63'h0, DivZero}, {63'h0, vtab[i].dz});
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vtab[i].lat));
            check($sformatf("vec%0d_busy", i), {63'h0, busy_ok}, 64'h1);
            consume(i % 3);
        end

        // Result held under back-pressure; in_valid ignored while busy
        model(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, exp_res, exp_lat);
        issue(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, lat, busy_ok);
        check("hold_res", {32'h0, ALUResult}, {32'h0, exp_res});
        held = ALUResult;
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; ALUControl = 4'b0010; srcA = $urandom; srcB = $urandom;
            @(posedge clk); #1;
            if (ALUResult !== held || !out_valid || in_ready) unstable++;
        end
        check("hold_stable", 64'(unstable), 64'h0);
        // in_valid still high across the consume edge: must not be accepted
        srcA = 32'h1; srcB = 32'h1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consume_no_accept_valid", {63'h0, out_valid}, 64'h0);
        check("consume_no_accept_ready", {63'h0, in_ready}, 64'h1);
        in_valid = 1'b0;
        model(4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F, exp_res, exp_lat);
        issue(4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F, lat, busy_ok);
        check("and_after_hold_res", {32'h0, ALUResult}, {32'h0, exp_res});
        check("and_after_hold_hi", {32'h0, Hi}, {32'h0, m_hi});
        check("and_after_hold_lo", {32'h0, Lo}, {32'h0, m_lo});
        consume(0);

        // Randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            int          sel;
            op  = rops[$urandom_range(0, 11)];
            a   = $urandom;
            sel = $urandom_range(0, 7);
            b   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            model(op, a, b, exp_res, exp_lat);
            issue(op, a, b, lat, busy_ok);
            check($sformatf("rnd%0d_res op=%b", n, op), {32'h0, ALUResult}, {32'h0, exp_res});
            check($sformatf("rnd%0d_zero", n), {63'h0, Zero}, {63'h0, exp_res == 32'h0});
            check($sformatf("rnd%0d_hi", n), {32'h0, Hi}, {32'h0, m_hi});
            check($sformatf("rnd%0d_lo", n), {32'h0, Lo}, {32'h0, m_lo});
            check($sformatf("rnd%0d_dz", n), {63'h0, DivZero}, {63'h0, m_dz});
            check($sformatf("rnd%0d_lat", n), 64'(lat), 64'(exp_lat));
            check($sformatf("rnd%0d_busy", n), {63'h0, busy_ok}, 64'h1);
            consume($urandom_range(0, 3));
        end

        // Reset in the middle of a MULTU
        check("pre_mid_rst_ready", {63'h0, in_ready}, 64'h1);
        srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF; ALUControl = 4'b1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0; m_dz = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
        check("mid_rst_result", {32'h0, ALUResult}, 64'h0);
        check("mid_rst_zero", {63'h0, Zero}, 64'h1);
        check("mid_rst_hi", {32'h0, Hi}, {32'h0, m_hi});
        check("mid_rst_lo", {32'h0, Lo}, {32'h0, m_lo});
        check("mid_rst_divzero", {63'h0, DivZero}, {63'h0, m_dz});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        check("post_rst_no_valid", 64'(seen), 64'h0);
        check("post_rst_hi", {32'h0, Hi}, 64'h0);
        check("post_rst_lo", {32'h0, Lo}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
